// File: rtl/simple_pkg.sv
// Shared types and phase constants for the SIMPLE processor timing path.
package simple_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    HALTED
  } state_t;

  localparam logic [2:0] PHASE_NONE   = 3'd0;
  localparam logic [2:0] PHASE_FIRST  = 3'd1;
  localparam logic [2:0] PHASE_DECODE = 3'd2;
  localparam logic [2:0] PHASE_LAST   = 3'd5;
  localparam int         NUM_PHASES   = 5;

  function automatic logic [NUM_PHASES:1] phase_onehot(
    input logic [2:0] p
  );
    logic [NUM_PHASES:1] v;
    v = '0;
    for (int i = 1; i <= NUM_PHASES; i++)
      v[i] = (p == 3'(i));
    return v;
  endfunction

endpackage

// File: rtl/phase_slot_timer.sv
// Slot/frame timer: walks phases 1..5, each SLOT_CYCLES long,
// and produces the registered phase clocks.
module phase_slot_timer
  import simple_pkg::*;
#(
  parameter int SLOT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  enable,
  output logic [2:0]            phase,
  output logic [NUM_PHASES:1]   pclk,
  output logic                  frame_end
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] LAST_CYC = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_CYC = CW'(SLOT_CYCLES / 2);

  logic [CW-1:0] cyc;

  assign frame_end = (phase == PHASE_LAST) && (cyc == LAST_CYC);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= PHASE_NONE;
      cyc   <= '0;
      pclk  <= '0;
    end else if (load) begin
      phase <= PHASE_FIRST;
      cyc   <= '0;
      pclk  <= phase_onehot(PHASE_FIRST);
    end else if (clear) begin
      phase <= PHASE_NONE;
      cyc   <= '0;
      pclk  <= '0;
    end else if (enable && phase != PHASE_NONE) begin
      if (cyc == LAST_CYC) begin
        cyc   <= '0;
        phase <= phase + 3'd1;
        pclk  <= phase_onehot(phase + 3'd1);
      end else begin
        cyc <= cyc + 1'b1;
        // phase clock drops after the first half of the slot
        if (cyc + 1'b1 == HALF_CYC)
          pclk <= '0;
      end
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Run/halt/step controller for the 5-phase SIMPLE datapath with
// HLT latch and retired-instruction counter.
module phase_sequencer
  import simple_pkg::*;
#(
  parameter int SLOT_CYCLES = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   step,
  input  logic                   halt_req,
  output logic                   clockp1,
  output logic                   clockp2,
  output logic                   clockp3,
  output logic                   clockp4,
  output logic                   clockp5,
  output logic [2:0]             phase,
  output logic                   running,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  state_t              state;
  logic                hlatch;
  logic                halt_now;
  logic                hlt_seen;
  logic                load;
  logic                clear;
  logic                enable;
  logic                frame_end;
  logic [NUM_PHASES:1] pclk;

  assign halt_now = stop | hlatch;
  assign hlt_seen = halt_req && (phase == PHASE_DECODE);

  always_comb begin
    load   = 1'b0;
    clear  = 1'b0;
    enable = 1'b0;
    unique case (state)
      IDLE:   load = start;
      RUN: begin
        if (frame_end) begin
          load  = !halt_now;
          clear = halt_now;
        end else begin
          enable = 1'b1;
        end
      end
      STEP: begin
        if (frame_end) clear = 1'b1;
        else           enable = 1'b1;
      end
      HALTED: load = start | step;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      running     <= 1'b0;
      halted      <= 1'b0;
      hlatch      <= 1'b0;
      instr_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (frame_end) begin
            instr_count <= instr_count + 1'b1;
            hlatch      <= 1'b0;
            if (halt_now) begin
              state   <= HALTED;
              running <= 1'b0;
              halted  <= 1'b1;
            end
          end else if (hlt_seen) begin
            hlatch <= 1'b1;
          end
        end
        STEP: begin
          if (frame_end) begin
            instr_count <= instr_count + 1'b1;
            hlatch      <= 1'b0;
            state       <= HALTED;
            running     <= 1'b0;
            halted      <= 1'b1;
          end else if (hlt_seen) begin
            hlatch <= 1'b1;
          end
        end
        HALTED: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
            halted  <= 1'b0;
          end else if (step) begin
            state   <= STEP;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  phase_slot_timer #(
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load),
    .clear    (clear),
    .enable   (enable),
    .phase    (phase),
    .pclk     (pclk),
    .frame_end(frame_end)
  );

  assign clockp1 = pclk[1];
  assign clockp2 = pclk[2];
  assign clockp3 = pclk[3];
  assign clockp4 = pclk[4];
  assign clockp5 = pclk[5];

endmodule
